cvmcu_dbg_req_ctrl: RTL and testbench
=====================================

# cvmcu_dbg_req_ctrl

Debug-request controller that sits directly upstream of the core's debug port. It collects halt requests from several on-chip sources and arbitrates them with fixed priority. It drives the core's `debug_req_i` line and waits for the core to enter debug mode, which it sees as the core's `stoptimer_o` rising. It also consumes `stoptimer_o` to freeze the system timer tick and to count cycles spent in debug.

## Interface
- `NUM_SRC`, 4: number of halt-request sources, 1..8.
- `TIMEOUT_CYCLES`, 1024: cycles in REQ without `stoptimer_i` before abandoning the request; minimum 2.
- `CNT_W`, 32: width of the debug-cycle counter.

- `clk`  in  1  system clock; single clock domain.
- `reset_n`  in  1  synchronous, active-low reset.
- `halt_req_i`  in  NUM_SRC  level halt request per source.
- `halt_ack_o`  out  NUM_SRC  one-cycle pulse: the source's request was honoured (core halted).
- `halt_err_o`  out  NUM_SRC  one-cycle pulse: the source's request timed out.
- `debug_req_o`  out  1  to the core's `debug_req_i`.
- `stoptimer_i`  in  1  from the core's `stoptimer_o`; high while the core is in debug mode.
- `timer_tick_i`  in  1  raw timer tick enable.
- `timer_tick_o`  out  1  gated timer tick.
- `dbg_cycles_o`  out  CNT_W  saturating count of cycles with `stoptimer_i` high.
- `clr_cnt_i`  in  1  synchronous clear of `dbg_cycles_o`.
- `active_src_o`  out  $clog2(NUM_SRC) (min 1)  index of the source being served.

## Operation
- Pending register `pend[NUM_SRC]`:
  - A bit sets on any cycle its `halt_req_i` is high.
  - A bit clears only when its source is acked or errored.
  - Set and clear in the same cycle: clear wins. A still-high request re-sets the bit on the following cycle.
- FSM states are IDLE, REQ, HALTED, RELEASE.
- IDLE:
  - If `pend != 0` and `stoptimer_i == 0`: latch the lowest-index pending source into `active_src_o`, go to REQ.
  - If `stoptimer_i == 1` (core halted by other means, e.g. ebreak): stay in IDLE and do not request.
- REQ:
  - `debug_req_o = 1`. The timeout counter increments from 0.
  - `stoptimer_i == 1`: pulse `halt_ack_o[active]`, clear `pend[active]`, go to HALTED.
  - Timeout counter reaches `TIMEOUT_CYCLES-1` and `stoptimer_i == 0`: pulse `halt_err_o[active]`, clear `pend[active]`, go to RELEASE.
  - `stoptimer_i` rising on the same cycle as the timeout: the ack wins.
- HALTED:
  - `debug_req_o = 0`.
  - `stoptimer_i == 0`: go to RELEASE.
- RELEASE:
  - One-cycle guard with `debug_req_o = 0`, then go to IDLE.
  - Guarantees at least 2 cycles of `debug_req_o` low between requests.
- `debug_req_o` is registered: it is high exactly for the cycles the FSM is in REQ, and rises the cycle after the IDLE→REQ decision.
- Cycle counter:
  - Increments on every cycle with `stoptimer_i == 1`, in any state.
  - Saturates at `2^CNT_W-1`.
  - `clr_cnt_i` wins over increment.
- Timer gate: `timer_tick_o` is registered from `timer_tick_i & ~stoptimer_i`.

## Timing
- All outputs are registered.
- Reset values: `debug_req_o = 0`, `halt_ack_o = 0`, `halt_err_o = 0`, `timer_tick_o = 0`, `dbg_cycles_o = 0`, `active_src_o = 0`. FSM resets to IDLE, `pend = 0`.
- Request latency: `halt_req_i` high at cycle N → `pend` set at N+1 → IDLE decision at N+1 → `debug_req_o` high at N+2.
- Ack latency: `stoptimer_i` sampled high in REQ at cycle M → `halt_ack_o` pulse and `debug_req_o` low at M+1.
- Timeout: `debug_req_o` is high for exactly `TIMEOUT_CYCLES` cycles, then `halt_err_o` pulses for one cycle.
- Tick gate latency is 1 cycle.
- Reset mid-operation: every register returns to its reset value on the next clock edge; `debug_req_o` drops the cycle after `reset_n` is sampled low.

## Structure
- `cvmcu_dbg_req_pkg` holds:
  - state enum `dbg_req_state_e` (IDLE, REQ, HALTED, RELEASE);
  - default parameter constants;
  - the source-index width function.
- Sub-module `cvmcu_dbg_req_arb`: combinational fixed-priority (lowest index) arbiter over `pend`, outputting `valid` and `idx`.
- Top level holds the FSM, the pending register, the timeout counter, the cycle counter and the tick gate.

## Test plan
- Single request: pulse `halt_req_i[2]` for 1 cycle; core model raises `stoptimer_i` 5 cycles after `debug_req_o` rises and holds it 20 cycles. Expect:
  - `halt_ack_o[2]` one pulse;
  - `dbg_cycles_o = 20`;
  - `timer_tick_o` stays 0 during the halt with `timer_tick_i` held at 1.
- Priority: raise `halt_req_i[3]` and `halt_req_i[1]` on the same cycle. Expect:
  - source 1 served first;
  - source 3 served after RELEASE;
  - `debug_req_o` low for at least 2 cycles between the two requests.
- Timeout: `TIMEOUT_CYCLES = 8`, core never responds. Expect:
  - `debug_req_o` high exactly 8 cycles;
  - `halt_err_o[0]` pulse;
  - no ack.
- Ack on the timeout cycle: `stoptimer_i` rises on cycle 7 of 8. Expect an ack, no error.
- Counter edges:
  - `CNT_W = 4`, hold `stoptimer_i` high for 20 cycles → `dbg_cycles_o = 15`;
  - assert `clr_cnt_i` together with increment → `dbg_cycles_o = 0`.
- Reset mid-REQ: drop `reset_n` while `debug_req_o = 1`. Expect:
  - `debug_req_o = 0` and `pend = 0` next cycle;
  - no ack or error pulse.

Source files
------------

// File: rtl/cvmcu_dbg_req_pkg.sv
// Shared types and defaults for the debug-request controller.
package cvmcu_dbg_req_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HALTED,
    RELEASE
  } dbg_req_state_e;

  localparam int unsigned DEF_NUM_SRC        = 4;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;
  localparam int unsigned DEF_CNT_W          = 32;

  // Source-index width; a single source still needs a 1-bit index.
  function automatic int unsigned src_idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cvmcu_dbg_req_arb.sv
// Fixed-priority arbiter over pending halt requests; lowest index wins.
import cvmcu_dbg_req_pkg::*;

module cvmcu_dbg_req_arb #(
  parameter  int unsigned NUM_SRC = DEF_NUM_SRC,
  localparam int unsigned IDX_W   = src_idx_w(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] pend,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  always_comb begin
    valid = |pend;
    idx   = '0;
    // Scan downwards so the lowest set index is the last one written.
    for (int unsigned i = NUM_SRC; i > 0; i--) begin
      if (pend[i-1]) idx = IDX_W'(i - 1);
    end
  end

endmodule

// File: rtl/cvmcu_dbg_req_ctrl.sv
// Debug-request controller: arbitrates halt sources, drives the core's debug
// request, gates the timer tick and counts cycles spent in debug mode.
import cvmcu_dbg_req_pkg::*;

module cvmcu_dbg_req_ctrl #(
  parameter  int unsigned NUM_SRC        = DEF_NUM_SRC,
  parameter  int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter  int unsigned CNT_W          = DEF_CNT_W,
  localparam int unsigned IDX_W          = src_idx_w(NUM_SRC)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_SRC-1:0] halt_req_i,
  output logic [NUM_SRC-1:0] halt_ack_o,
  output logic [NUM_SRC-1:0] halt_err_o,
  output logic               debug_req_o,
  input  logic               stoptimer_i,
  input  logic               timer_tick_i,
  output logic               timer_tick_o,
  output logic [CNT_W-1:0]   dbg_cycles_o,
  input  logic               clr_cnt_i,
  output logic [IDX_W-1:0]   active_src_o
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES);

  dbg_req_state_e     state_q, state_d;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] ack_d, err_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [IDX_W-1:0]   active_d;
  logic               arb_valid;
  logic [IDX_W-1:0]   arb_idx;

  cvmcu_dbg_req_arb #(
    .NUM_SRC(NUM_SRC)
  ) u_arb (
    .pend (pend_q),
    .valid(arb_valid),
    .idx  (arb_idx)
  );

  always_comb begin
    state_d  = state_q;
    to_cnt_d = to_cnt_q;
    active_d = active_src_o;
    ack_d    = '0;
    err_d    = '0;
    unique case (state_q)
      IDLE: begin
        // A core already halted by other means (e.g. ebreak) is not requested.
        if (arb_valid && !stoptimer_i) begin
          active_d = arb_idx;
          to_cnt_d = '0;
          state_d  = REQ;
        end
      end
      REQ: begin
        if (stoptimer_i) begin
          ack_d[active_src_o] = 1'b1;
          state_d             = HALTED;
        end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          err_d[active_src_o] = 1'b1;
          state_d             = RELEASE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      HALTED: begin
        if (!stoptimer_i) state_d = RELEASE;
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Clearing the served source wins over a request arriving in the same cycle.
    pend_d = (pend_q | halt_req_i) & ~(ack_d | err_d);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      pend_q       <= '0;
      to_cnt_q     <= '0;
      active_src_o <= '0;
      halt_ack_o   <= '0;
      halt_err_o   <= '0;
      debug_req_o  <= 1'b0;
      timer_tick_o <= 1'b0;
      dbg_cycles_o <= '0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      to_cnt_q     <= to_cnt_d;
      active_src_o <= active_d;
      halt_ack_o   <= ack_d;
      halt_err_o   <= err_d;
      debug_req_o  <= (state_d == REQ);
      timer_tick_o <= timer_tick_i & ~stoptimer_i;
      if (clr_cnt_i) begin
        dbg_cycles_o <= '0;
      end else if (stoptimer_i && (dbg_cycles_o != '1)) begin
        dbg_cycles_o <= dbg_cycles_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cvmcu_dbg_req_ctrl.sv
// Bench for cvmcu_dbg_req_ctrl: directed scenarios plus random traffic
// compared every cycle against a behavioural model.
module tb_cvmcu_dbg_req_ctrl;

  localparam int TO = 8;

  localparam int M_IDLE    = 0;
  localparam int M_WAITING = 1;
  localparam int M_IN_DBG  = 2;
  localparam int M_GUARD   = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n = 1'b0;
  logic [3:0] h = '0;
  logic       st = 1'b0, tick = 1'b0, clr = 1'b0;

  logic [3:0] ack_a, err_a, ack_b, err_b;
  logic       req_a, req_b, tick_a, tick_b;
  logic [7:0] cyc_a;
  logic [3:0] cyc_b;
  logic [1:0] src_a, src_b;

  cvmcu_dbg_req_ctrl #(.NUM_SRC(4), .TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .halt_req_i(h), .halt_ack_o(ack_a),
    .halt_err_o(err_a), .debug_req_o(req_a), .stoptimer_i(st),
    .timer_tick_i(tick), .timer_tick_o(tick_a), .dbg_cycles_o(cyc_a),
    .clr_cnt_i(clr), .active_src_o(src_a)
  );

  cvmcu_dbg_req_ctrl #(.NUM_SRC(4), .TIMEOUT_CYCLES(TO), .CNT_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .halt_req_i(h), .halt_ack_o(ack_b),
    .halt_err_o(err_b), .debug_req_o(req_b), .stoptimer_i(st),
    .timer_tick_i(tick), .timer_tick_o(tick_b), .dbg_cycles_o(cyc_b),
    .clr_cnt_i(clr), .active_src_o(src_b)
  );

  int n_pass = 0, n_chk = 0;
  int n_ack[4], n_err[4], n_req_hi;

  // Behavioural model state
  bit [3:0] m_pend, m_ack, m_err;
  int       m_mode, m_wait, m_active;
  bit       m_req, m_tick;
  longint   m_cnt;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic longint sat(input longint v, input int w);
    longint mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_step(input bit [3:0] hi, input bit sti, ticki, clri, rsti);
    m_ack = '0;
    m_err = '0;
    if (!rsti) begin
      m_pend = '0; m_mode = M_IDLE; m_wait = 0; m_active = 0;
      m_req = 0; m_tick = 0; m_cnt = 0;
      return;
    end
    case (m_mode)
      M_IDLE: if (m_pend != 0 && !sti) begin
        for (int i = 3; i >= 0; i--) if (m_pend[i]) m_active = i;
        m_mode = M_WAITING;
        m_wait = 0;
      end
      M_WAITING: begin
        if (sti) begin
          m_ack[m_active] = 1'b1; m_mode = M_IN_DBG;
        end else if (m_wait == TO - 1) begin
          m_err[m_active] = 1'b1; m_mode = M_GUARD;
        end else begin
          m_wait++;
        end
      end
      M_IN_DBG: if (!sti) m_mode = M_GUARD;
      default: m_mode = M_IDLE;
    endcase
    m_pend = (m_pend | hi) & ~(m_ack | m_err);
    m_req  = (m_mode == M_WAITING);
    m_tick = ticki & ~sti;
    if (clri) m_cnt = 0;
    else if (sti) m_cnt++;
  endtask

  task automatic cyc(input bit [3:0] hi, input bit sti, ticki, clri, rsti);
    @(negedge clk);
    h = hi; st = sti; tick = ticki; clr = clri; reset_n = rsti;
    model_step(hi, sti, ticki, clri, rsti);
    @(posedge clk);
    #1;
    chk("debug_req",  req_a,  m_req);
    chk("halt_ack",   ack_a,  m_ack);
    chk("halt_err",   err_a,  m_err);
    chk("timer_tick", tick_a, m_tick);
    chk("active_src", src_a,  m_active);
    chk("dbg_cycles", cyc_a,  sat(m_cnt, 8));
    chk("debug_req4", req_b,  m_req);
    chk("halt_ack4",  ack_b,  m_ack);
    chk("halt_err4",  err_b,  m_err);
    chk("dbg_cycles4", cyc_b, sat(m_cnt, 4));
    for (int i = 0; i < 4; i++) begin
      n_ack[i] += int'(ack_a[i]);
      n_err[i] += int'(err_a[i]);
    end
    n_req_hi += int'(req_a);
  endtask

  task automatic clr_stats();
    for (int i = 0; i < 4; i++) begin n_ack[i] = 0; n_err[i] = 0; end
    n_req_hi = 0;
  endtask

  task automatic wait_req(input string tag);
    int i = 0;
    while (!req_a && i < 20) begin cyc(4'b0, 0, 1, 0, 1); i++; end
    chk({tag, "_req_rise"}, req_a, 1);
  endtask

  function automatic int tot(input int a[4]);
    return a[0] + a[1] + a[2] + a[3];
  endfunction

  initial begin
    int tick_hi, gap;
    bit stv, rst;
    bit [3:0] hi;
    clr_stats();

    // Reset state
    repeat (2) cyc(4'b0, 0, 1, 0, 0);
    chk("rst_debug_req", req_a, 0);
    chk("rst_tick", tick_a, 0);
    chk("rst_cycles", cyc_a, 0);

    // Single request from source 2, core halts for 20 cycles
    cyc(4'b0, 0, 1, 1, 1);
    clr_stats();
    cyc(4'b0100, 0, 1, 0, 1);
    wait_req("s1");
    chk("s1_src", src_a, 2);
    repeat (4) cyc(4'b0, 0, 1, 0, 1);
    tick_hi = 0;
    repeat (20) begin cyc(4'b0, 1, 1, 0, 1); tick_hi += int'(tick_a); end
    chk("s1_tick_gated", tick_hi, 0);
    chk("s1_cycles", cyc_a, 20);
    chk("s1_cycles_sat4", cyc_b, 15);
    repeat (4) cyc(4'b0, 0, 1, 0, 1);
    chk("s1_ack2", n_ack[2], 1);
    chk("s1_acks", tot(n_ack), 1);
    chk("s1_errs", tot(n_err), 0);

    // Priority: sources 1 and 3 together
    clr_stats();
    cyc(4'b1010, 0, 1, 0, 1);
    wait_req("s2a");
    chk("s2_first_src", src_a, 1);
    repeat (2) cyc(4'b0, 0, 1, 0, 1);
    repeat (3) cyc(4'b0, 1, 1, 0, 1);
    gap = 0;
    while (!req_a && gap < 20) begin cyc(4'b0, 0, 1, 0, 1); gap++; end
    chk("s2_gap_ok", (gap >= 3) && req_a, 1);
    chk("s2_second_src", src_a, 3);
    repeat (2) cyc(4'b0, 1, 1, 0, 1);
    repeat (3) cyc(4'b0, 0, 1, 0, 1);
    chk("s2_ack1", n_ack[1], 1);
    chk("s2_ack3", n_ack[3], 1);

    // Timeout: core never responds
    clr_stats();
    cyc(4'b0001, 0, 1, 0, 1);
    wait_req("s3");
    repeat (12) cyc(4'b0, 0, 1, 0, 1);
    chk("s3_req_len", n_req_hi, TO);
    chk("s3_err0", n_err[0], 1);
    chk("s3_no_ack", tot(n_ack), 0);

    // Core halts on the last REQ cycle: ack beats timeout
    clr_stats();
    cyc(4'b0001, 0, 1, 0, 1);
    wait_req("s4");
    repeat (TO - 1) cyc(4'b0, 0, 1, 0, 1);
    cyc(4'b0, 1, 1, 0, 1);
    repeat (2) cyc(4'b0, 1, 1, 0, 1);
    repeat (3) cyc(4'b0, 0, 1, 0, 1);
    chk("s4_req_len", n_req_hi, TO);
    chk("s4_ack0", n_ack[0], 1);
    chk("s4_no_err", tot(n_err), 0);

    // Counter clear beats increment; core already halted defers request
    clr_stats();
    repeat (3) cyc(4'b0, 1, 0, 0, 1);
    cyc(4'b0, 1, 0, 1, 1);
    chk("s5_clr_wins", cyc_a, 0);
    chk("s5_clr_wins4", cyc_b, 0);
    cyc(4'b0100, 1, 0, 0, 1);
    repeat (4) cyc(4'b0, 1, 0, 0, 1);
    chk("s5_no_req_halted", n_req_hi, 0);
    cyc(4'b0, 0, 0, 0, 1);
    wait_req("s5");
    cyc(4'b0, 1, 0, 0, 1);
    repeat (3) cyc(4'b0, 0, 0, 0, 1);
    chk("s5_ack2", n_ack[2], 1);

    // Reset in the middle of a request
    clr_stats();
    cyc(4'b0010, 0, 1, 0, 1);
    wait_req("s6");
    cyc(4'b0, 0, 1, 0, 0);
    chk("s6_req_dropped", req_a, 0);
    repeat (6) cyc(4'b0, 0, 1, 0, 1);
    chk("s6_req_count", n_req_hi, 1);
    chk("s6_no_ack", tot(n_ack), 0);
    chk("s6_no_err", tot(n_err), 0);

    // Random traffic with a reactive core
    stv = 0;
    for (int k = 0; k < 600; k++) begin
      hi = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0;
      if (stv) begin
        if ($urandom_range(0, 5) == 0) stv = 0;
      end else if (m_req && $urandom_range(0, 3) == 0) begin
        stv = 1;
      end else if ($urandom_range(0, 60) == 0) begin
        stv = 1;
      end
      rst = ($urandom_range(0, 150) != 0);
      cyc(hi, stv, 1'($urandom_range(0, 1)), ($urandom_range(0, 30) == 0), rst);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
